modexp_ctrl: RTL

- Sequencer for RSA modular exponentiation. It computes result = base^exponent mod modulus by driving a shared external modular multiplier over a start/done handshake.
- It uses left-to-right square-and-multiply and scans every exponent bit, MSB first.
- It sits between the key-gen/encrypt/decrypt control and the multiplier. One instance serves both the encrypt and decrypt passes.
- A cycle counter reports each operation's duration for timing-side-channel measurement.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/modexp_ctrl_if.sv | 23 ++
 rtl/modexp_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared constants and FSM state encoding for the modexp_ctrl exponentiation sequencer.
package rsa_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_EXP_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 32;

    // Fixed start-to-done latency of the reference multiplier used by the bench.
    localparam int MUL_LAT = 4;

    typedef enum logic [2:0] {
        IDLE,
        SQR_REQ,
        SQR_WAIT,
        MUL_REQ,
        MUL_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/modexp_ctrl_if.sv
// Start/done handshake between the exponentiation sequencer and the shared modular multiplier.
interface modexp_ctrl_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_n;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;

    modport master (
        output mul_start, mul_a, mul_b, mul_n,
        input  mul_done, mul_p
    );

    modport slave (
        input  mul_start, mul_a, mul_b, mul_n,
        output mul_done, mul_p
    );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external modular multiplier.
// Define MODEXP_CONST_TIME_EN to issue a (possibly dummy) multiply on every exponent bit.
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    modexp_ctrl_if.master        mul
);
    localparam int                   IDX_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IDX_W-1:0]     IDX_TOP = IDX_W'(EXP_WIDTH - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);

    state_t               state;
    logic [WIDTH-1:0]     base_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [IDX_W-1:0]     idx;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 bit_set;
    logic                 last_bit;
    logic                 do_mul;
    logic [WIDTH-1:0]     mul_keep;

    // mul.mul_a carries the running accumulator while a request is in flight,
    // so it doubles as acc and no separate register is kept.
    assign bit_set  = exp_q[idx];
    assign last_bit = (idx == '0);

`ifdef MODEXP_CONST_TIME_EN
    assign do_mul   = 1'b1;
    assign mul_keep = bit_set ? mul.mul_p : mul.mul_a;
`else
    assign do_mul   = bit_set;
    assign mul_keep = mul.mul_p;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            result        <= '0;
            cycle_cnt     <= '0;
            mul.mul_start <= 1'b0;
            mul.mul_a     <= '0;
            mul.mul_b     <= '0;
            mul.mul_n     <= '0;
            base_q        <= '0;
            exp_q         <= '0;
            idx           <= '0;
            cnt           <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are re-raised by the one
            // branch below that needs them; the later non-blocking write wins.
            mul.mul_start <= 1'b0;
            done          <= 1'b0;
            if (busy) cnt <= cnt + CNT_ONE;

            case (state)
                IDLE: if (start) begin
                    base_q    <= base;
                    exp_q     <= exponent;
                    mul.mul_n <= modulus;
                    idx       <= IDX_TOP;
                    cnt       <= CNT_ONE;
                    err       <= (modulus == '0);
                    if (modulus == '0) begin
                        result    <= '0;
                        done      <= 1'b1;
                        cycle_cnt <= CNT_ONE;
                        state     <= DONE;
                    end else begin
                        busy          <= 1'b1;
                        mul.mul_start <= 1'b1;
                        mul.mul_a     <= (modulus == ONE) ? '0 : ONE;
                        mul.mul_b     <= (modulus == ONE) ? '0 : ONE;
                        state         <= SQR_REQ;
                    end
                end

                SQR_REQ: state <= SQR_WAIT;

                SQR_WAIT: if (mul.mul_done) begin
                    if (do_mul) begin
                        mul.mul_start <= 1'b1;
                        mul.mul_a     <= mul.mul_p;
                        mul.mul_b     <= base_q;
                        state         <= MUL_REQ;
                    end else if (last_bit) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= mul.mul_p;
                        cycle_cnt <= cnt + CNT_ONE;
                        state     <= DONE;
                    end else begin
                        idx           <= idx - IDX_ONE;
                        mul.mul_start <= 1'b1;
                        mul.mul_a     <= mul.mul_p;
                        mul.mul_b     <= mul.mul_p;
                        state         <= SQR_REQ;
                    end
                end

                MUL_REQ: state <= MUL_WAIT;

                MUL_WAIT: if (mul.mul_done) begin
                    if (last_bit) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= mul_keep;
                        cycle_cnt <= cnt + CNT_ONE;
                        state     <= DONE;
                    end else begin
                        idx           <= idx - IDX_ONE;
                        mul.mul_start <= 1'b1;
                        mul.mul_a     <= mul_keep;
                        mul.mul_b     <= mul_keep;
                        state         <= SQR_REQ;
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
